// File: rtl/muxed_enable_register_if.sv
// Data-side bundle for muxed_enable_register: two candidate words, select, write enable,
// plus the observed mux output and registered value.
interface muxed_enable_register_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             sel;
    logic             enable;
    logic [WIDTH-1:0] d_mux;
    logic [WIDTH-1:0] q;

    modport master (
        output d0,
        output d1,
        output sel,
        output enable,
        input  d_mux,
        input  q
    );

    modport slave (
        input  d0,
        input  d1,
        input  sel,
        input  enable,
        output d_mux,
        output q
    );
endinterface

// File: rtl/muxed_enable_register.sv
// CP0 storage element: a 2:1 vector mux feeding an enabled flop bank with an
// asynchronous, active-high reset to a configurable value.

module mux2v #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel
);
    // An unknown select propagates as unknown data rather than favouring either input.
    always_comb begin
        out = 'x;
        case (sel)
            1'b0:    out = A;
            1'b1:    out = B;
            default: out = 'x;
        endcase
    end
endmodule

module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             enable,
    input  logic             reset
);
    // Reset may be a combinational term such as ERET || reset, so it is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (enable) begin
            q <= d;
        end
    end
endmodule

module muxed_enable_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    muxed_enable_register_if.slave  bus
);
    logic [WIDTH-1:0] d_mux;
    logic [WIDTH-1:0] q;

    mux2v #(WIDTH) u_mux (d_mux, bus.d0, bus.d1, bus.sel);

    register #(WIDTH, RESET_VALUE) u_reg (q, d_mux, clock, bus.enable, reset);

    assign bus.d_mux = d_mux;
    assign bus.q     = q;
endmodule

// File: tb/tb_muxed_enable_register.sv
// Randomised and directed checks of muxed_enable_register at widths 32, 64 and 1
// against a behavioural model of the capture/hold/reset rules.
module tb_muxed_enable_register;
    localparam logic [31:0] RV32 = 32'h0000_FF01;
    localparam logic [63:0] RV64 = 64'h0;
    localparam logic [0:0]  RV1  = 1'b0;

    logic clock;
    logic reset;

    muxed_enable_register_if #(.WIDTH(32)) if32 ();
    muxed_enable_register_if #(.WIDTH(64)) if64 ();
    muxed_enable_register_if #(.WIDTH(1))  if1  ();

    muxed_enable_register #(.WIDTH(32), .RESET_VALUE(RV32)) dut32 (.clock(clock), .reset(reset), .bus(if32.slave));
    muxed_enable_register #(.WIDTH(64), .RESET_VALUE(RV64)) dut64 (.clock(clock), .reset(reset), .bus(if64.slave));
    muxed_enable_register #(.WIDTH(1),  .RESET_VALUE(RV1))  dut1  (.clock(clock), .reset(reset), .bus(if1.slave));

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp32;
    logic [63:0] exp64;
    logic [0:0]  exp1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: reset forces the reset value, otherwise an enabled edge captures the selected word.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            exp32 = RV32;
            exp64 = RV64;
            exp1  = RV1;
        end else begin
            if (if32.enable) exp32 = if32.sel ? if32.d1 : if32.d0;
            if (if64.enable) exp64 = if64.sel ? if64.d1 : if64.d0;
            if (if1.enable)  exp1  = if1.sel  ? if1.d1  : if1.d0;
        end
        #1;
    endtask

    task automatic check_q(input string tag);
        check_val({tag, "_q32"}, {32'h0, if32.q}, {32'h0, exp32});
        check_val({tag, "_q64"}, if64.q, exp64);
        check_val({tag, "_q1"},  {63'h0, if1.q}, {63'h0, exp1});
    endtask

    task automatic randomize_inputs();
        if32.d0     = $urandom;
        if32.d1     = $urandom;
        if32.sel    = 1'($urandom_range(0, 1));
        if32.enable = 1'($urandom_range(0, 1));
        if64.d0     = {$urandom, $urandom};
        if64.d1     = {$urandom, $urandom};
        if64.sel    = 1'($urandom_range(0, 1));
        if64.enable = 1'($urandom_range(0, 1));
        if1.d0      = 1'($urandom_range(0, 1));
        if1.d1      = 1'($urandom_range(0, 1));
        if1.sel     = 1'($urandom_range(0, 1));
        if1.enable  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset = 1'b1;
        if32.d0 = '0; if32.d1 = '0; if32.sel = 1'b0; if32.enable = 1'b0;
        if64.d0 = '0; if64.d1 = '0; if64.sel = 1'b0; if64.enable = 1'b0;
        if1.d0  = '0; if1.d1  = '0; if1.sel  = 1'b0; if1.enable  = 1'b0;
        exp32 = RV32;
        exp64 = RV64;
        exp1  = RV1;

        // Reset value appears before any clock edge.
        #1;
        check_val("reset_nocl_q32", {32'h0, if32.q}, 64'h0000_FF01);
        check_val("reset_nocl_q64", if64.q, 64'h0);
        check_val("reset_nocl_q1",  {63'h0, if1.q}, 64'h0);

        // Enable during reset: reset wins.
        if32.enable = 1'b1; if32.d0 = 32'h1234_5678;
        if64.enable = 1'b1; if64.d0 = 64'h5555;
        if1.enable  = 1'b1; if1.sel = 1'b1; if1.d1 = 1'b1;
        tick();
        check_val("reset_en_q32", {32'h0, if32.q}, 64'h0000_FF01);
        check_val("reset_en_q1",  {63'h0, if1.q}, 64'h0);

        // Deassert, clock with enable low: value holds.
        @(negedge clock);
        reset = 1'b0;
        if32.enable = 1'b0; if64.enable = 1'b0; if1.enable = 1'b0;
        tick();
        tick();
        check_val("hold_after_reset", {32'h0, if32.q}, 64'h0000_FF01);
        check_q("post_reset");

        // Combinational mux, no clock required.
        @(negedge clock);
        if64.d0 = 64'h1111_2222_3333_4444;
        if64.d1 = 64'hAAAA_BBBB_CCCC_DDDD;
        if64.sel = 1'b0;
        #1 check_val("mux64_sel0", if64.d_mux, 64'h1111_2222_3333_4444);
        if64.sel = 1'b1;
        #1 check_val("mux64_sel1", if64.d_mux, 64'hAAAA_BBBB_CCCC_DDDD);
        check_val("mux64_noload", if64.q, 64'h0);

        // EPC capture via d1, then d0.
        @(negedge clock);
        if32.sel = 1'b1; if32.d1 = 32'h0040_0010; if32.enable = 1'b1;
        if64.sel = 1'b0; if64.d0 = 64'h0000_0000_DEAD_BEEF; if64.enable = 1'b1;
        tick();
        check_val("epc_d1", {32'h0, if32.q}, 64'h0040_0010);
        check_val("load64", if64.q, 64'hDEAD_BEEF);
        @(negedge clock);
        if32.sel = 1'b0; if32.d0 = 32'hDEAD_BEEF;
        tick();
        check_val("epc_d0", {32'h0, if32.q}, 64'hDEAD_BEEF);

        // Hold for 5 edges while data and select wander.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            randomize_inputs();
            if32.enable = 1'b0; if64.enable = 1'b0; if1.enable = 1'b0;
            tick();
            check_val("hold_q32", {32'h0, if32.q}, 64'hDEAD_BEEF);
        end

        // Reset pulse between edges clears immediately.
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_val("midpulse_q64", if64.q, 64'h0);
        check_val("midpulse_q32", {32'h0, if32.q}, 64'h0000_FF01);
        exp32 = RV32; exp64 = RV64; exp1 = RV1;
        #1 reset = 1'b0;
        check_q("after_pulse");

        // Reset held with enable=1 across an edge.
        @(negedge clock);
        reset = 1'b1;
        if64.enable = 1'b1; if64.sel = 1'b1; if64.d1 = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check_val("reset_wins_q64", if64.q, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        if64.enable = 1'b0;

        // WIDTH=1 EXL style.
        @(negedge clock);
        if1.d1 = 1'b1; if1.d0 = 1'b0; if1.sel = 1'b1; if1.enable = 1'b1;
        tick();
        check_val("exl_set", {63'h0, if1.q}, 64'h1);
        @(negedge clock);
        if1.enable = 1'b0;
        #1 reset = 1'b1;
        #1 check_val("exl_reset", {63'h0, if1.q}, 64'h0);
        exp32 = RV32; exp64 = RV64; exp1 = RV1;
        #1 reset = 1'b0;

        // Randomised run with occasional mid-cycle reset pulses.
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            randomize_inputs();
            #1;
            check_val("rnd_dmux32", {32'h0, if32.d_mux}, {32'h0, (if32.sel ? if32.d1 : if32.d0)});
            check_val("rnd_dmux64", if64.d_mux, (if64.sel ? if64.d1 : if64.d0));
            check_val("rnd_dmux1",  {63'h0, if1.d_mux}, {63'h0, (if1.sel ? if1.d1 : if1.d0)});
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                exp32 = RV32; exp64 = RV64; exp1 = RV1;
                #1 check_q("rnd_pulse");
                reset = 1'b0;
            end
            tick();
            check_q("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
